// File: rtl/accel_seed_loader_if.sv
// ---------------------------------------------------------------------------
// accel_seed_loader_if
//   Host word stream into the seed loader.
//   s_valid : host beat valid
//   s_ready : loader accepts beat (a beat transfers on s_valid & s_ready)
//   s_data  : header or entry word
//   s_last  : final beat of a load
//   master modport = host side, slave modport = loader side.
// ---------------------------------------------------------------------------
interface accel_seed_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/accel_seed_loader.sv
// ---------------------------------------------------------------------------
// accel_seed_loader
//   Unpacks a host stream (header N, then N pairs of InexRecur/state words)
//   into the InexRecur and state regfiles through their random-write ports,
//   then raises is_start until the host stops the run. Because the loader
//   owns is_start, no regfile write can ever overlap a running accelerator.
//
// Ports
//   clk, rst                   : clock, async active-high reset
//   s (slave modport)          : host stream s_valid/s_ready/s_data/s_last
//   stop                       : end the run (only honoured in RUN)
//   clr                        : abort/clear to IDLE from any state
//   ran_we/w_addr/w_data_InexRecur        : InexRecur write port
//   ran_we/w_addr/w_data_state_external   : state write port
//   is_start                   : accelerator run enable
//   busy                       : not IDLE
//   err                        : protocol error (held until clr)
//   loaded_n                   : entries fully written in current/last load
// ---------------------------------------------------------------------------
module accel_seed_loader #(
    parameter int ADDR_W = 12,
    parameter int IR_W   = 32,
    parameter int ST_W   = 18,
    parameter int MAX_N  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    accel_seed_loader_if.slave    s,
    input  logic                  stop,
    input  logic                  clr,
    output logic                  ran_we_InexRecur,
    output logic [ADDR_W-1:0]     ran_w_addr_InexRecur,
    output logic [IR_W-1:0]       ran_w_data_InexRecur,
    output logic                  ran_we_state_external,
    output logic [ADDR_W-1:0]     ran_w_addr_state_external,
    output logic [ST_W-1:0]       ran_w_data_state_external,
    output logic                  is_start,
    output logic                  busy,
    output logic                  err,
    output logic [12:0]           loaded_n
);

    localparam int CNT_W = 13;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_IR = 3'd1,
        LOAD_ST = 3'd2,
        FLUSH   = 3'd3,
        RUN     = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    loaded_q, loaded_d;

    logic                ir_we_q, ir_we_d;
    logic [ADDR_W-1:0]   ir_addr_q, ir_addr_d;
    logic [IR_W-1:0]     ir_data_q, ir_data_d;
    logic                st_we_q, st_we_d;
    logic [ADDR_W-1:0]   st_addr_q, st_addr_d;
    logic [ST_W-1:0]     st_data_q, st_data_d;

    logic                s_ready_w;
    logic                accept;
    logic [CNT_W-1:0]    hdr_n;
    logic                hdr_bad;
    logic                is_final;

    // Loader only takes beats in IDLE (header) and the two LOAD states;
    // there is no backpressure inside a load.
    assign s_ready_w = (state_q == IDLE) || (state_q == LOAD_IR) || (state_q == LOAD_ST);
    assign accept    = s.s_valid & s_ready_w;

    assign hdr_n     = s.s_data[CNT_W-1:0];
    assign hdr_bad   = (hdr_n == '0) || (hdr_n > CNT_W'(MAX_N)) || s.s_last;
    assign is_final  = (CNT_W'(idx_q) == (n_q - CNT_W'(1)));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        loaded_d  = loaded_q;
        ir_we_d   = 1'b0;
        ir_addr_d = ir_addr_q;
        ir_data_d = ir_data_q;
        st_we_d   = 1'b0;
        st_addr_d = st_addr_q;
        st_data_d = st_data_q;

        // clr beats everything, including a beat accepted this same cycle:
        // no strobe is registered and loaded_n keeps its value.
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            state_d = ERR;
                        end else begin
                            state_d  = LOAD_IR;
                            idx_d    = '0;
                            n_d      = hdr_n;
                            loaded_d = '0;
                        end
                    end
                end
                LOAD_IR: begin
                    if (accept) begin
                        if (s.s_last) begin
                            state_d = ERR;
                        end else begin
                            ir_we_d   = 1'b1;
                            ir_addr_d = idx_q;
                            ir_data_d = s.s_data[IR_W-1:0];
                            state_d   = LOAD_ST;
                        end
                    end
                end
                LOAD_ST: begin
                    if (accept) begin
                        // The state write goes out even when the framing is
                        // wrong; the error is flagged after it.
                        st_we_d   = 1'b1;
                        st_addr_d = idx_q;
                        st_data_d = s.s_data[ST_W-1:0];
                        loaded_d  = loaded_q + CNT_W'(1);
                        if (s.s_last != is_final) begin
                            state_d = ERR;
                        end else if (is_final) begin
                            state_d = FLUSH;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = LOAD_IR;
                        end
                    end
                end
                // One dead cycle so the last state strobe lands while
                // is_start is still low.
                FLUSH:   state_d = RUN;
                RUN:     if (stop) state_d = IDLE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            loaded_q  <= '0;
            ir_we_q   <= 1'b0;
            ir_addr_q <= '0;
            ir_data_q <= '0;
            st_we_q   <= 1'b0;
            st_addr_q <= '0;
            st_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            loaded_q  <= loaded_d;
            ir_we_q   <= ir_we_d;
            ir_addr_q <= ir_addr_d;
            ir_data_q <= ir_data_d;
            st_we_q   <= st_we_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
        end
    end

    assign s.s_ready                 = s_ready_w;
    assign ran_we_InexRecur          = ir_we_q;
    assign ran_w_addr_InexRecur      = ir_addr_q;
    assign ran_w_data_InexRecur      = ir_data_q;
    assign ran_we_state_external     = st_we_q;
    assign ran_w_addr_state_external = st_addr_q;
    assign ran_w_data_state_external = st_data_q;
    assign is_start                  = (state_q == RUN);
    assign busy                      = (state_q != IDLE);
    assign err                       = (state_q == ERR);
    assign loaded_n                  = loaded_q;

endmodule

// File: doc/accel_seed_loader.md
# accel_seed_loader

Upstream loader for the FM-index inexact-recursion accelerator. It accepts a host word stream, unpacks a header plus N seed entries, and writes each entry into the InexRecur and state register files through their external random-write ports. It then raises `is_start` so the FSM can consume the seeded regfiles, and holds it until the host stops the run. It owns the `is_start` handover, so no external write ever overlaps a running accelerator.

## Interface
Parameters:
- `ADDR_W`, 12: regfile address width.
- `IR_W`, 32: InexRecur entry width.
- `ST_W`, 18: state entry width.
- `MAX_N`, 4096: maximum entries per load.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `s_valid` in 1: host beat valid.
- `s_ready` out 1: loader accepts beat; a beat transfers when `s_valid & s_ready`.
- `s_data` in 32: header or entry word.
- `s_last` in 1: marks the final beat of a load.
- `stop` in 1: end the run; return to IDLE.
- `clr` in 1: abort or clear from any state to IDLE.
- `ran_we_InexRecur` out 1: InexRecur write strobe.
- `ran_w_addr_InexRecur` out ADDR_W: InexRecur write address.
- `ran_w_data_InexRecur` out IR_W: InexRecur write data.
- `ran_we_state_external` out 1: state write strobe.
- `ran_w_addr_state_external` out ADDR_W: state write address.
- `ran_w_data_state_external` out ST_W: state write data.
- `is_start` out 1: accelerator run enable.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: protocol error flag, sticky until `clr`.
- `loaded_n` out 13: number of entries fully written in the current or last load.

## Operation
- Stream format:
  - Beat 0 is the header: `s_data[12:0]` = N, valid range 1..MAX_N; upper bits are ignored.
  - Then N pairs follow: an InexRecur beat (all 32 bits), then a state beat (`s_data[ST_W-1:0]`, upper bits ignored).
  - Entry k is written to address k in both regfiles.
- States:
  - IDLE: `s_ready`=1. A header beat with N in range → LOAD_IR, entry index idx=0, `loaded_n`=0. N=0, N>MAX_N, or `s_last`=1 on the header → ERR.
  - LOAD_IR: `s_ready`=1. On accept, register the word and idx, pulse `ran_we_InexRecur` → LOAD_ST. `s_last`=1 → ERR with no write.
  - LOAD_ST: `s_ready`=1. On accept, pulse `ran_we_state_external` at addr idx and increment `loaded_n`. The beat's `s_last` is checked against idx==N-1:
    - match and last → FLUSH;
    - match and not last → idx+1, LOAD_IR;
    - mismatch (`s_last` early, or missing on the final entry) → ERR. The write of that beat is still issued.
  - FLUSH: one cycle; `s_ready`=0. Guarantees the final state write is seen while `is_start`=0 → RUN.
  - RUN: `is_start`=1, `s_ready`=0. `stop`=1 → IDLE.
  - ERR: `err`=1, `s_ready`=0, no writes. Waits for `clr`.
- `clr` has priority over every transition and `stop`. It forces IDLE next cycle, cancels any pending strobe, and zeroes `err`. `loaded_n` is retained.
- `stop` outside RUN is ignored.
- Write strobes are mutually exclusive and last one cycle. Address/data are held stable from the strobe cycle until the next strobe.

## Timing
- Reset values: all outputs 0 except `s_ready`=1 (IDLE). Every address/data output reads 0.
- Reset mid-load stops writes immediately. No partial strobe may appear after `rst` deasserts.
- Write latency is 1 cycle: a beat accepted at edge T produces its strobe in the cycle after T.
- Sustained rate is one beat per cycle with no backpressure in the LOAD states. A full load takes 1+2N beats.
- Final state beat accepted at T: state strobe in cycle T+1 (FLUSH), `is_start`=1 from T+2.
- `stop` sampled at T: `is_start`=0 and `busy`=0 from T+1.
- `loaded_n` updates in the same cycle as the state strobe.
- idx never wraps: N≤MAX_N bounds it to MAX_N-1.

## Test plan
- Load N=2: header 2, then IR 0xDEADBEEF, ST 0x3FFFF, IR 0x12345678, ST 0x00001 + last → IR writes (0,0xDEADBEEF) and (1,0x12345678); state writes (0,0x3FFFF) and (1,0x00001); `loaded_n`=2. `is_start` rises exactly 2 cycles after the last beat.
- Header N=0, and separately N=4097 → `err`=1, `s_ready`=0, no strobes. `clr` → IDLE, `err`=0.
- N=3 with `s_last` on the 2nd state beat → 2 state writes issued, then ERR, `loaded_n`=2. Repeat with `s_last` missing on the 3rd state beat → ERR, `loaded_n`=3.
- N=4096 back-to-back beats with `s_valid` held high → 8192 strobes at addresses 0..4095, no gaps, then RUN.
- `s_valid` toggled randomly during a load → each write occurs only on accepted beats; addresses stay in order.
- `rst` asserted mid-LOAD_ST, and `stop` together with `clr` in RUN → all outputs drop to reset values or IDLE next cycle; `is_start`=0; no strobe after the event.
